sync_fifo_ctrl: RTL



---
 rtl/sync_fifo_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with live fill count, programmable almost-full/empty thresholds,
// sticky overflow/underflow flags, synchronous flush, and STD_FIFO or FWFT read mode.
module sync_fifo_ctrl #(
  parameter int    DATA_WIDTH = 8,
  parameter int    ADDR_WIDTH = 8,
  parameter string FIFO_MODE  = "STD_FIFO"
) (
  input  logic                  i_clk,
  input  logic                  i_arstn,
  input  logic                  i_we,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic                  i_flush,
  input  logic [ADDR_WIDTH:0]   i_afull_th,
  input  logic [ADDR_WIDTH:0]   i_aempty_th,
  input  logic                  i_clr_err,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_afull,
  output logic                  o_aempty,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_underflow
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam bit IS_FWFT = (FIFO_MODE == "FWFT");
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d, ram_cnt;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  valid_q, valid_d;
  logic                  empty_q, empty_d, full_q, full_d;
  logic                  afull_q, afull_d, aempty_q, aempty_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic                  wa, ra, ld;

  assign wa = i_we & ~full_q & ~i_flush;
  assign ra = i_re & ~empty_q & ~i_flush;
  // In FWFT the output register holds one of the counted words; RAM holds the rest.
  assign ram_cnt = count_q - {{ADDR_WIDTH{1'b0}}, valid_q};
  assign ld = IS_FWFT ? (~i_flush & (ram_cnt != '0) & (~valid_q | ra)) : ra;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    rdata_d = rdata_q;
    valid_d = valid_q;
    if (i_flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      valid_d = 1'b0;
    end else begin
      if (wa) wptr_d = wptr_q + PTR_ONE;
      if (ld) begin
        rptr_d  = rptr_q + PTR_ONE;
        rdata_d = mem_q[rptr_q];
      end
      if (IS_FWFT) begin
        if (ld)      valid_d = 1'b1;
        else if (ra) valid_d = 1'b0;
      end
      case ({wa, ra})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
    empty_d  = IS_FWFT ? ~valid_d : (count_d == '0);
    full_d   = (count_d == DEPTH_C);
    afull_d  = (count_d >= i_afull_th);
    aempty_d = (count_d <= i_aempty_th);
    ovf_d    = (i_we & full_q) | (ovf_q & ~i_clr_err);
    udf_d    = (i_re & empty_q) | (udf_q & ~i_clr_err);
  end

  always_ff @(posedge i_clk) begin
    if (wa) mem_q[wptr_q] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      valid_q  <= 1'b0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      valid_q  <= valid_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign o_rdata     = rdata_q;
  assign o_full      = full_q;
  assign o_empty     = empty_q;
  assign o_afull     = afull_q;
  assign o_aempty    = aempty_q;
  assign o_count     = count_q;
  assign o_overflow  = ovf_q;
  assign o_underflow = udf_q;
endmodule
